// File: rtl/dist_query_issuer_if.sv
// Host/sorter-facing bus of dist_query_issuer: bank load, run control and the issue/return stream.
interface dist_query_issuer_if #(
    parameter int VEC_W  = 64,
    parameter int ADDR_W = 4
);
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [VEC_W-1:0]  load_data;
    logic              start;
    logic [VEC_W-1:0]  query_in;
    logic [ADDR_W:0]   num_vecs;
    logic              out_valid;
    logic [VEC_W-1:0]  query;
    logic [VEC_W-1:0]  search_0;
    logic              in_valid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_valid, load_addr, load_data, start, query_in, num_vecs, out_valid,
        input  query, search_0, in_valid, busy, done, err
    );

    modport slave (
        input  load_valid, load_addr, load_data, start, query_in, num_vecs, out_valid,
        output query, search_0, in_valid, busy, done, err
    );
endinterface

// File: rtl/dist_query_issuer.sv
// Query/search-vector issuer for dist_sort_simple with outstanding-beat limiting.
// Optional macro DIST_ISSUE_GAP_EN: forces an idle cycle between consecutive in_valid beats.
module dist_query_issuer #(
    parameter int VEC_W        = 64,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clk,
    input  logic               rst,
    dist_query_issuer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      MAX_C   = 4'(MAX_INFLIGHT);

    logic [VEC_W-1:0] bank [DEPTH];

    state_t           state_q, state_d;
    logic [ADDR_W:0]  idx_q, idx_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic [3:0]       inflight_q, inflight_d;
    logic [VEC_W-1:0] qlat_q, qlat_d;
    logic [VEC_W-1:0] query_q, query_d;
    logic [VEC_W-1:0] search_q, search_d;
    logic             in_valid_q, in_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             gap_ok, ret, issue;

    always_comb begin
`ifdef DIST_ISSUE_GAP_EN
        gap_ok = !in_valid_q;
`else
        gap_ok = 1'b1;
`endif
        ret   = bus.out_valid && (inflight_q != '0);
        // A return in the same cycle frees its slot for this cycle's issue.
        issue = (state_q == ISSUE) && gap_ok && ((inflight_q < MAX_C) || ret);

        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        qlat_d     = qlat_q;
        query_d    = query_q;
        search_d   = search_q;
        in_valid_d = issue;
        err_d      = err_q | (bus.out_valid && (inflight_q == '0));

        case ({issue, ret})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase

        if (issue) begin
            search_d = bank[idx_q[ADDR_W-1:0]];
            query_d  = qlat_q;
            idx_d    = idx_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    qlat_d  = bus.query_in;
                    cnt_d   = (bus.num_vecs > DEPTH_C) ? DEPTH_C : bus.num_vecs;
                    idx_d   = '0;
                    state_d = (bus.num_vecs == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue && (idx_q == cnt_q - 1'b1)) state_d = DRAIN;
            end
            DRAIN: begin
                if ((inflight_q == '0) && !in_valid_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
            qlat_q     <= '0;
            query_q    <= '0;
            search_q   <= '0;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            qlat_q     <= qlat_d;
            query_q    <= query_d;
            search_q   <= search_d;
            in_valid_q <= in_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Bank has no reset; contents are only meaningful once loaded.
    always_ff @(posedge clk) begin
        if (bus.load_valid && (state_q == IDLE)) bank[bus.load_addr] <= bus.load_data;
    end

    assign bus.query    = query_q;
    assign bus.search_0 = search_q;
    assign bus.in_valid = in_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_dist_query_issuer.sv
// Self-checking bench for dist_query_issuer: directed scenarios plus randomized runs against a bank/scoreboard model.
module tb_dist_query_issuer;
    localparam int VEC_W        = 64;
    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int MAX_INFLIGHT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dist_query_issuer_if #(.VEC_W(VEC_W), .ADDR_W(ADDR_W)) bus ();

    dist_query_issuer #(
        .VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int               checks;
    int               errors;
    logic             err_exp;
    logic [VEC_W-1:0] bank_m [DEPTH];

    task automatic load(input int a, input logic [VEC_W-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_addr  = ADDR_W'(a);
        bus.load_data  = d;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bank_m[a] = d;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.in_valid, bus.busy, bus.done, bus.err} !== 4'b0 || bus.search_0 !== '0 || bus.query !== '0) begin
            errors++;
            $display("FAIL reset_held: iv/busy/done/err=%b search_0=%h query=%h, want all 0",
                     {bus.in_valid, bus.busy, bus.done, bus.err}, bus.search_0, bus.query);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_valid, bus.busy, bus.done, bus.err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: iv/busy/done/err=%b, want 0000", {bus.in_valid, bus.busy, bus.done, bus.err});
        end
    endtask

    task automatic test_back_to_back();
        logic [VEC_W-1:0] q;
        int               beats;
        int               rets;
        logic             exp_iv;
        bit               done_seen;
        q = 64'hddabaaef1c450b1;
        for (int i = 0; i < 4; i++) load(i, 64'h11223344556677 + 64'(i));
        bus.start = 1'b1; bus.num_vecs = 5'd4; bus.query_in = q;
        @(negedge clk);
        bus.start = 1'b0;
        beats = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
`ifdef DIST_ISSUE_GAP_EN
            exp_iv = (c % 2 == 1) && (c <= 7);
`else
            exp_iv = (c <= 4);
`endif
            checks++;
            if (bus.in_valid !== exp_iv) begin
                errors++;
                $display("FAIL b2b_in_valid c%0d: got %b want %b", c, bus.in_valid, exp_iv);
            end
            if (bus.in_valid && beats < 4) begin
                checks++;
                if (bus.search_0 !== bank_m[beats] || bus.query !== q) begin
                    errors++;
                    $display("FAIL b2b_data beat%0d: search_0=%h query=%h want %h/%h",
                             beats, bus.search_0, bus.query, bank_m[beats], q);
                end
            end
            if (bus.in_valid) beats++;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy c%0d: got %b want 1", c, bus.busy);
            end
        end
        rets = 0; done_seen = 0;
        for (int k = 0; k < 30 && !done_seen; k++) begin
            if (bus.done) done_seen = 1;
            else begin
                bus.out_valid = (rets < beats);
                if (bus.out_valid) rets++;
                @(negedge clk);
            end
        end
        bus.out_valid = 1'b0;
        checks++;
        if (!done_seen || beats != 4 || rets != 4) begin
            errors++;
            $display("FAIL b2b_done: done_seen=%0d beats=%0d rets=%0d want 1/4/4", done_seen, beats, rets);
        end
        @(negedge clk);
    endtask

    task automatic test_inflight();
        logic [VEC_W-1:0] q;
        logic [VEC_W-1:0] exp_s;
        int               beats;
        int               rets;
        bit               done_seen;
        q = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) load(i, {$urandom, $urandom});
        bus.start = 1'b1; bus.num_vecs = 5'd8; bus.query_in = q;
        @(negedge clk);
        bus.start = 1'b0;
        beats = 0; rets = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.in_valid) beats++;
        end
        checks++;
        if (beats != MAX_INFLIGHT) begin
            errors++;
            $display("FAIL inflight_stall: beats=%0d want %0d", beats, MAX_INFLIGHT);
        end
        bus.out_valid = 1'b1; rets++;
        @(negedge clk);
        bus.out_valid = 1'b0;
        checks++;
        if (bus.in_valid !== 1'b1 || bus.search_0 !== bank_m[MAX_INFLIGHT]) begin
            errors++;
            $display("FAIL inflight_resume: in_valid=%b search_0=%h want 1/%h",
                     bus.in_valid, bus.search_0, bank_m[MAX_INFLIGHT]);
        end
        if (bus.in_valid) beats++;
        @(negedge clk);
        checks++;
        if (bus.in_valid !== 1'b0) begin
            errors++;
            $display("FAIL inflight_restall: in_valid=%b want 0", bus.in_valid);
        end
        done_seen = 0;
        for (int k = 0; k < 100 && !done_seen; k++) begin
            if (bus.in_valid) begin
                exp_s = (beats < 8) ? bank_m[beats] : '1;
                checks++;
                if (beats >= 8 || bus.search_0 !== exp_s || bus.query !== q) begin
                    errors++;
                    $display("FAIL inflight_data beat%0d: search_0=%h want %h", beats, bus.search_0, exp_s);
                end
                beats++;
            end
            if (bus.done) done_seen = 1;
            else begin
                bus.out_valid = (beats > rets);
                if (bus.out_valid) rets++;
                @(negedge clk);
            end
        end
        bus.out_valid = 1'b0;
        checks++;
        if (!done_seen || beats != 8 || rets != 8) begin
            errors++;
            $display("FAIL inflight_done: done_seen=%0d beats=%0d rets=%0d want 1/8/8", done_seen, beats, rets);
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int iters);
        int               n, nexp, beats, rets, dones, done_cyc, la, pct;
        logic [VEC_W-1:0] q, ld, exp_s;
        bit               prev_iv, poke;
        for (int i = 0; i < DEPTH; i++) load(i, {$urandom, $urandom});
        for (int it = 0; it < iters; it++) begin
            n    = (it == 0) ? 1 : (it == 1) ? 0 : (it == 2) ? 20 : (it == 3) ? 5 : $urandom_range(0, DEPTH + 4);
            poke = (it == 3);
            pct  = $urandom_range(10, 90);
            q    = {$urandom, $urandom};
            ld   = {$urandom, $urandom};
            la   = $urandom_range(0, DEPTH - 1);
            nexp = (n > DEPTH) ? DEPTH : n;
            bus.start = 1'b1; bus.num_vecs = (ADDR_W+1)'(n); bus.query_in = q;
            bus.load_valid = 1'b1; bus.load_addr = ADDR_W'(la); bus.load_data = ld;
            bank_m[la] = ld;
            @(negedge clk);
            bus.start = 1'b0; bus.load_valid = 1'b0;
            beats = 0; rets = 0; dones = 0; done_cyc = -1; prev_iv = 0;
            for (int c = 0; c < 400; c++) begin
                if (bus.in_valid) begin
                    exp_s = (beats < nexp) ? bank_m[beats] : '1;
                    checks++;
                    if (beats >= nexp || bus.search_0 !== exp_s || bus.query !== q) begin
                        errors++;
                        $display("FAIL rand_beat it%0d beat%0d: search_0=%h query=%h want %h/%h (n=%0d)",
                                 it, beats, bus.search_0, bus.query, exp_s, q, nexp);
                    end
                    if (beats == 0) begin
                        checks++;
                        if (c != 1) begin
                            errors++;
                            $display("FAIL rand_latency it%0d: first beat at cycle %0d want 1", it, c);
                        end
                    end
`ifdef DIST_ISSUE_GAP_EN
                    checks++;
                    if (prev_iv) begin
                        errors++;
                        $display("FAIL rand_gap it%0d: in_valid high on consecutive cycles", it);
                    end
`endif
                    beats++;
                end
                prev_iv = bus.in_valid;
                checks++;
                if (beats - rets > MAX_INFLIGHT) begin
                    errors++;
                    $display("FAIL rand_inflight it%0d: outstanding %0d want <= %0d", it, beats - rets, MAX_INFLIGHT);
                end
                checks++;
                if (bus.err !== err_exp || bus.busy !== ((nexp > 0) && !bus.done)) begin
                    errors++;
                    $display("FAIL rand_status it%0d c%0d: err=%b busy=%b want %b/%b",
                             it, c, bus.err, bus.busy, err_exp, (nexp > 0) && !bus.done);
                end
                if (bus.done) begin
                    dones++; done_cyc = c;
                    break;
                end
                if (poke && c == 2) begin
                    bus.load_valid = 1'b1; bus.load_addr = '0; bus.load_data = ~bank_m[0];
                    bus.start = 1'b1; bus.num_vecs = 5'd3;
                end else begin
                    bus.load_valid = 1'b0; bus.start = 1'b0;
                end
                bus.out_valid = (beats > rets) && ($urandom_range(0, 99) < pct);
                if (bus.out_valid) rets++;
                @(negedge clk);
            end
            bus.out_valid = 1'b0; bus.start = 1'b0; bus.load_valid = 1'b0;
            checks++;
            if (dones != 1 || beats != nexp || rets != beats || (nexp == 0 && done_cyc != 0)) begin
                errors++;
                $display("FAIL rand_run it%0d: dones=%0d beats=%0d rets=%0d done_cyc=%0d want 1/%0d/%0d",
                         it, dones, beats, rets, done_cyc, nexp, nexp);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_after_done it%0d: done=%b busy=%b want 0/0", it, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_err();
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: err=%b want 0", bus.err);
        end
        bus.out_valid = 1'b1;
        @(negedge clk);
        bus.out_valid = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL err_set: err=%b busy=%b want 1/0", bus.err, bus.busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b want 1", bus.err);
        end
        err_exp = 1'b1;
    endtask

    task automatic test_reset_mid();
        int beats;
        beats = 0;
        bus.start = 1'b1; bus.num_vecs = 5'd6; bus.query_in = {$urandom, $urandom};
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            @(negedge clk);
            if (bus.in_valid) beats++;
        end
        checks++;
        if (beats != 2) begin
            errors++;
            $display("FAIL rstmid_beats: beats=%0d want 2", beats);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.in_valid, bus.busy, bus.done, bus.err} !== 4'b0 || bus.search_0 !== '0 || bus.query !== '0) begin
            errors++;
            $display("FAIL rstmid_async: iv/busy/done/err=%b search_0=%h query=%h want all 0",
                     {bus.in_valid, bus.busy, bus.done, bus.err}, bus.search_0, bus.query);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_valid, bus.busy, bus.done, bus.err} !== 4'b0) begin
                errors++;
                $display("FAIL rstmid_after c%0d: iv/busy/done/err=%b want 0000", c,
                         {bus.in_valid, bus.busy, bus.done, bus.err});
            end
        end
        err_exp = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; err_exp = 1'b0;
        rst = 1'b0;
        bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.start = 1'b0; bus.query_in = '0; bus.num_vecs = '0; bus.out_valid = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_back_to_back();
        test_inflight();
        test_random(12);
        test_err();
        test_random(3);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
